// File: rtl/bitty_pkg.sv
//==============================================================================
// Module      : bitty_pkg
// Description : Shared encodings for the parametrised Bitty core (modes, ALU
//               ops, FSM states, compare results).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package bitty_pkg;

  typedef enum logic [1:0] {
    MODE_RR  = 2'b00,
    MODE_RI  = 2'b01,
    MODE_MEM = 2'b10,
    MODE_NOP = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_CMP = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADS = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4
  } state_e;

  localparam logic [1:0] CMP_EQ = 2'd0;
  localparam logic [1:0] CMP_GT = 2'd1;
  localparam logic [1:0] CMP_LT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/bitty_alu_param.sv
//==============================================================================
// Module      : bitty_alu_param
// Description : Combinational DW-bit ALU for the Bitty core.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bitty_alu_param
  import bitty_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_op_e       op,
  output logic [DW-1:0] y
);

  localparam int c_SW = $clog2(DW);

  // Only the low log2(DW) bits of b select the shift distance.
  logic [c_SW-1:0] w_shamt;
  assign w_shamt = b[c_SW-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SHL: y = a << w_shamt;
      ALU_SHR: y = a >> w_shamt;
      ALU_CMP: begin
        if (a == b)     y = DW'(CMP_EQ);
        else if (a > b) y = DW'(CMP_GT);
        else            y = DW'(CMP_LT);
      end
      default: y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bitty_core_param.sv
//==============================================================================
// Module      : bitty_core_param
// Description : Parametrised Bitty execution core: 8-entry register file, ALU
//               and req/ack load/store port behind a multi-cycle FSM.
//               Optional memory timeout: define BITTY_MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bitty_core_param
  import bitty_pkg::*;
#(
  parameter int DW             = 16,
  parameter int AW             = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] d_out,
  output logic          done,
  output logic          mem_err
);

  state_e          r_state;
  logic [15:0]     r_instr;
  logic [DW-1:0]   r_regs [8];
  logic [DW-1:0]   r_s;
  logic [DW-1:0]   r_c;
  logic            r_done;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;

  logic [2:0]      w_rx;
  logic [2:0]      w_ry;
  logic [7:0]      w_imm8;
  logic [2:0]      w_op;
  mode_e           w_mode;
  logic [DW-1:0]   w_operand;
  logic [DW-1:0]   w_alu_y;
  logic            w_wb_en;
  logic            w_abort;

  assign w_rx   = r_instr[15:13];
  assign w_ry   = r_instr[12:10];
  assign w_imm8 = r_instr[12:5];
  assign w_op   = r_instr[4:2];
  assign w_mode = mode_e'(r_instr[1:0]);

  assign w_operand = (w_mode == MODE_RI) ? DW'(w_imm8) : r_regs[w_ry];
  assign w_wb_en   = (w_mode == MODE_RR) || (w_mode == MODE_RI) ||
                     ((w_mode == MODE_MEM) && !w_op[0]);

  bitty_alu_param #(.DW(DW)) u_alu (
    .a  (r_s),
    .b  (w_operand),
    .op (alu_op_e'(w_op)),
    .y  (w_alu_y)
  );

`ifdef BITTY_MEM_TIMEOUT_EN
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_TW-1:0] r_tmo_cnt;
  logic            r_mem_err;
  assign mem_err = r_mem_err;
  assign w_abort = r_mem_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign mem_err      = 1'b0;
  assign w_abort      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_instr     <= '0;
      r_s         <= '0;
      r_c         <= '0;
      r_done      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
`ifdef BITTY_MEM_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_mem_err   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef BITTY_MEM_TIMEOUT_EN
      r_mem_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= ST_LOADS;
          end
        end
        ST_LOADS: begin
          r_s <= r_regs[w_rx];
          if (w_mode == MODE_MEM) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_op[0];
            r_mem_addr  <= r_regs[w_ry][AW-1:0];
            r_mem_wdata <= r_regs[w_rx];
`ifdef BITTY_MEM_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
            r_state     <= ST_MEM;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Reserved mode retires through the same path but leaves C alone.
          if (w_mode != MODE_NOP) r_c <= w_alu_y;
          r_done  <= 1'b1;
          r_state <= ST_WB;
        end
        ST_MEM: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_c       <= r_mem_we ? r_s : mem_rdata;
            r_done    <= 1'b1;
            r_state   <= ST_WB;
          end
`ifdef BITTY_MEM_TIMEOUT_EN
          else if (r_tmo_cnt == c_TW'(TIMEOUT_CYCLES - 1)) begin
            r_mem_req <= 1'b0;
            r_mem_err <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= ST_WB;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        ST_WB: begin
          if (w_wb_en && !w_abort) r_regs[w_rx] <= r_c;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == ST_IDLE);
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign d_out       = r_c;
  assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bitty_core_param.sv
//==============================================================================
// Module      : tb_bitty_core_param
// Description : Directed vector bench for bitty_core_param (DW=16, AW=8).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bitty_core_param;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, CMP = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] d_out;
  logic        done;
  logic        mem_err;

  int n_total = 0;
  int n_bad   = 0;

  bitty_core_param #(.DW(16), .AW(8), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .d_out       (d_out),
    .done        (done),
    .mem_err     (mem_err)
  );

  always #5 clk = ~clk;

  // Memory slave: acks after ack_delay waiting cycles of an outstanding request.
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic [15:0] rdata_val = '0;
  always @(negedge clk) begin
    if (mem_req && !mem_ack) begin
      if (wait_cnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata_val;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ri(input logic [2:0] rx, input logic [7:0] imm, input logic [2:0] op);
    return {rx, imm, op, 2'b01};
  endfunction
  function automatic logic [15:0] rr(input logic [2:0] rx, input logic [2:0] ry, input logic [2:0] op);
    return {rx, ry, 5'b0, op, 2'b00};
  endfunction
  function automatic logic [15:0] mm(input logic [2:0] rx, input logic [2:0] ry, input logic st);
    return {rx, ry, 5'b0, 2'b00, st, 2'b10};
  endfunction

  // Results of the most recent run_instr call.
  int          t_lat, t_reqs;
  logic        t_err, t_timed_out, t_unstable, t_we;
  logic [15:0] t_d, t_wdata;
  logic [7:0]  t_addr;

  task automatic run_instr(input logic [15:0] ins, input int maxc);
    t_lat = 0; t_reqs = 0; t_err = 0; t_timed_out = 1; t_unstable = 0;
    t_d = '0; t_we = 0; t_wdata = '0; t_addr = '0;
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    while (t_lat < maxc) begin
      @(negedge clk);
      t_lat++;
      if (mem_req) begin
        if (t_reqs == 0) begin
          t_addr = mem_addr; t_we = mem_we; t_wdata = mem_wdata;
        end else if (mem_addr !== t_addr || mem_we !== t_we || mem_wdata !== t_wdata) begin
          t_unstable = 1;
        end
        t_reqs++;
      end
      if (done) begin
        t_err = mem_err;
        t_d = d_out;
        t_timed_out = 0;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [15:0] exp_d;
  } vec_t;
  vec_t vt[20];

  initial begin
    vt[0]  = '{ri(1, 8'h05, ADD), 16'h0005};
    vt[1]  = '{ri(1, 8'h00, OR_), 16'h0005};
    vt[2]  = '{rr(1, 1, XOR_),    16'h0000};
    vt[3]  = '{ri(2, 8'h01, ADD), 16'h0001};
    vt[4]  = '{rr(1, 2, SUB),     16'hFFFF};
    vt[5]  = '{rr(1, 2, CMP),     16'h0001};
    vt[6]  = '{rr(1, 2, CMP),     16'h0000};
    vt[7]  = '{rr(1, 2, CMP),     16'h0002};
    vt[8]  = '{ri(3, 8'hFF, ADD), 16'h00FF};
    vt[9]  = '{ri(3, 8'h04, SHL), 16'h0FF0};
    vt[10] = '{ri(3, 8'h14, SHL), 16'hFF00};
    vt[11] = '{ri(3, 8'h08, SHR), 16'h00FF};
    vt[12] = '{ri(3, 8'h0F, AND_), 16'h000F};
    vt[13] = '{rr(3, 3, ADD),     16'h001E};
    vt[14] = '{rr(2, 3, SUB),     16'hFFE3};
    vt[15] = '{16'b010_00000000_000_11, 16'hFFE3};
    vt[16] = '{ri(2, 8'h00, OR_), 16'hFFE3};
    vt[17] = '{ri(2, 8'h1D, ADD), 16'h0000};
    vt[18] = '{rr(3, 3, XOR_),    16'h0000};
    vt[19] = '{ri(3, 8'h40, ADD), 16'h0040};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset instr_ready", instr_ready, 1);
    chk("reset mem_req", mem_req, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset d_out", d_out, 0);
    chk("reset done", done, 0);
    chk("reset mem_err", mem_err, 0);

    for (int i = 0; i < 20; i++) begin
      run_instr(vt[i].ins, 20);
      chk($sformatf("vec%0d d_out", i), t_d, vt[i].exp_d);
      chk($sformatf("vec%0d latency", i), t_lat, 3);
      chk($sformatf("vec%0d mem_req", i), t_reqs, 0);
      chk($sformatf("vec%0d mem_err", i), t_err, 0);
      @(negedge clk);
      chk($sformatf("vec%0d done pulse", i), done, 0);
    end

    // Load R4 <- [R3], ack after 3 waiting cycles.
    ack_delay = 3; rdata_val = 16'hBEEF;
    run_instr(mm(4, 3, 1'b0), 30);
    chk("load latency", t_lat, 6);
    chk("load req cycles", t_reqs, 4);
    chk("load addr", t_addr, 8'h40);
    chk("load we", t_we, 0);
    chk("load stable", t_unstable, 0);
    chk("load d_out", t_d, 16'hBEEF);
    run_instr(ri(4, 8'h00, OR_), 20);
    chk("R4 after load", t_d, 16'hBEEF);

    // Store R4 -> [R3], immediate ack, instr_valid held high across retire.
    ack_delay = 0; rdata_val = 16'h1234;
    begin
      int lat, reqs;
      logic seen;
      lat = 0; reqs = 0; seen = 0;
      @(negedge clk);
      instr = mm(4, 3, 1'b1);
      instr_valid = 1'b1;
      while (lat < 20 && !seen) begin
        @(negedge clk);
        lat++;
        if (mem_req) begin
          reqs++;
          chk("store we", mem_we, 1);
          chk("store wdata", mem_wdata, 16'hBEEF);
          chk("store addr", mem_addr, 8'h40);
        end
        if (done) seen = 1;
      end
      chk("store latency", lat, 3);
      chk("store req cycles", reqs, 1);
      chk("store d_out", d_out, 16'hBEEF);
      instr = ri(4, 8'h00, OR_);
      @(negedge clk);
      chk("b2b ready after wb", instr_ready, 1);
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      chk("b2b accepted", instr_ready, 0);
      lat = 1; seen = 0;
      while (lat < 20 && !seen) begin
        @(negedge clk);
        lat++;
        if (done) seen = 1;
      end
      chk("b2b latency", lat, 3);
      chk("R4 after store", d_out, 16'hBEEF);
    end

    run_instr(ri(5, 8'h33, ADD), 20);
    chk("R5 set", t_d, 16'h0033);

    ack_delay = 1000;
`ifdef BITTY_MEM_TIMEOUT_EN
    run_instr(mm(5, 3, 1'b0), 40);
    chk("timeout latency", t_lat, 10);
    chk("timeout req cycles", t_reqs, 8);
    chk("timeout mem_err", t_err, 1);
    chk("timeout C kept", t_d, 16'h0033);
    @(negedge clk);
    chk("mem_err pulse", mem_err, 0);
    chk("req dropped", mem_req, 0);
    run_instr(ri(5, 8'h00, OR_), 20);
    chk("R5 kept", t_d, 16'h0033);
    run_instr(mm(5, 3, 1'b0), 3);
`else
    run_instr(mm(5, 3, 1'b0), 100);
    chk("no-ack hang", t_timed_out, 1);
    chk("mem_err tied", mem_err, 0);
`endif

    // Reset in the middle of a pending memory request.
    chk("pre-reset mem_req", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("async mem_req drop", mem_req, 0);
    chk("async ready", instr_ready, 1);
    chk("async d_out", d_out, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_instr(ri(4, 8'h00, OR_), 20);
    chk("R4 cleared", t_d, 16'h0000);
    run_instr(ri(3, 8'h00, OR_), 20);
    chk("R3 cleared", t_d, 16'h0000);
    run_instr(ri(5, 8'h00, OR_), 20);
    chk("R5 cleared", t_d, 16'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
